// File: rtl/pipelined_decode_stage.sv
// pipelined_decode_stage
//   MIPS decode stage. Decodes the incoming instruction into a 24-bit control
//   word and registers it, with the destination register and the raw
//   instruction, into the ID/EX pipeline register. The stage has a valid/ready
//   handshake on both sides. It also provides a load-use stall, a flush, a
//   syscall drain/halt state machine and an illegal-opcode pulse.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   handshake from the IF/ID register
//   instr               instruction word
//   out_valid/out_ready handshake toward EX
//   ctrl_o, wreg_o,     registered control word, destination reg and instruction
//   instr_o
//   flush               kill ID/EX contents and block accept this cycle
//   resume              leave HALTED
//   halted_o            halted by syscall
//   illegal_o           one-cycle pulse after an undecodable instr is accepted
module pipelined_decode_stage #(
  parameter int LOAD_USE_STALL = 1,
  parameter int DRAIN_CYCLES   = 3,
  parameter int CTRL_W         = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [4:0]        wreg_o,
  output logic [31:0]       instr_o,
  input  logic              flush,
  input  logic              resume,
  output logic              halted_o,
  output logic              illegal_o
);
  // control word bit positions
  localparam int B_MTR = 4,  B_MW  = 5,  B_SRC = 6,  B_RW  = 7,  B_SX   = 8;
  localparam int B_RDST = 9, B_BEQ = 10, B_BNE = 11, B_JR  = 12, B_JMP  = 13;
  localparam int B_JAL = 14, B_SHV = 15, B_LUI = 16, B_BLEZ = 17, B_BGTZ = 18;
  localparam int B_BZ  = 19, B_BYTE = 22, B_SX2 = 23;

  localparam int SCW = (LOAD_USE_STALL > 1) ? $clog2(LOAD_USE_STALL) : 1;
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [SCW-1:0] STALL_RELOAD = SCW'((LOAD_USE_STALL > 0) ? LOAD_USE_STALL - 1 : 0);
  localparam logic [DCW-1:0] DRAIN_RELOAD = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  logic [5:0]        op, func;
  logic [CTRL_W-1:0] dec, ctrl_n;
  logic [3:0]        alu;
  logic              legal, is_sys;
  logic [4:0]        wreg_n;

  assign op   = instr[31:26];
  assign func = instr[5:0];

  // ---------------- decode ----------------
  always_comb begin
    dec   = '0;
    alu   = 4'd13;
    legal = 1'b1;
    if (op == 6'd0) begin
      case (func)
        6'd0:         alu = 4'd0;
        6'd2:         alu = 4'd2;
        6'd3:         alu = 4'd1;
        6'd4:         begin alu = 4'd0; dec[B_SHV] = 1'b1; end
        6'd6:         begin alu = 4'd2; dec[B_SHV] = 1'b1; end
        6'd7:         begin alu = 4'd1; dec[B_SHV] = 1'b1; end
        6'd8, 6'd12:  alu = 4'd13;
        6'd32, 6'd33: alu = 4'd5;
        6'd34, 6'd35: alu = 4'd6;
        6'd36:        alu = 4'd7;
        6'd37:        alu = 4'd8;
        6'd38:        alu = 4'd9;
        6'd39:        alu = 4'd10;
        6'd42:        alu = 4'd11;
        6'd43:        alu = 4'd12;
        default:      legal = 1'b0;
      endcase
      // jr and syscall are the only R-types without a register result
      dec[B_RW]   = legal && (func != 6'd8) && (func != 6'd12);
      dec[B_RDST] = dec[B_RW];
      dec[B_JR]   = (func == 6'd8);
      dec[B_JMP]  = (func == 6'd8);
    end else begin
      case (op)
        6'd1:  begin dec[B_BZ]   = 1'b1; dec[B_SX] = 1'b1; end
        6'd2:  dec[B_JMP] = 1'b1;
        6'd3:  begin dec[B_JMP]  = 1'b1; dec[B_JAL] = 1'b1; dec[B_RW] = 1'b1; end
        6'd4:  begin dec[B_BEQ]  = 1'b1; dec[B_SX] = 1'b1; end
        6'd5:  begin dec[B_BNE]  = 1'b1; dec[B_SX] = 1'b1; end
        6'd6:  begin dec[B_BLEZ] = 1'b1; dec[B_SX] = 1'b1; end
        6'd7:  begin dec[B_BGTZ] = 1'b1; dec[B_SX] = 1'b1; end
        6'd8, 6'd9: begin alu = 4'd5;  dec[B_SRC] = 1'b1; dec[B_RW] = 1'b1; dec[B_SX] = 1'b1; end
        6'd10: begin alu = 4'd11; dec[B_SRC] = 1'b1; dec[B_RW] = 1'b1; dec[B_SX] = 1'b1; end
        6'd11: begin alu = 4'd12; dec[B_SRC] = 1'b1; dec[B_RW] = 1'b1; dec[B_SX] = 1'b1; end
        // logical immediates are zero-extended
        6'd12: begin alu = 4'd7;  dec[B_SRC] = 1'b1; dec[B_RW] = 1'b1; end
        6'd13: begin alu = 4'd8;  dec[B_SRC] = 1'b1; dec[B_RW] = 1'b1; end
        6'd14: begin alu = 4'd9;  dec[B_SRC] = 1'b1; dec[B_RW] = 1'b1; end
        6'd15: begin alu = 4'd0;  dec[B_SRC] = 1'b1; dec[B_RW] = 1'b1; dec[B_LUI] = 1'b1; end
        6'd32, 6'd33, 6'd35, 6'd36, 6'd37: begin
          alu = 4'd5;
          dec[B_MTR] = 1'b1; dec[B_SRC] = 1'b1; dec[B_RW] = 1'b1; dec[B_SX] = 1'b1;
        end
        6'd40, 6'd41, 6'd43: begin
          alu = 4'd5;
          dec[B_MW] = 1'b1; dec[B_SRC] = 1'b1; dec[B_SX] = 1'b1;
        end
        default: legal = 1'b0;
      endcase
      // access size: op[1:0] 00 byte, 01 half, 11 word across loads/stores
      if (op[5]) begin
        dec[21:20]  = (op[1:0] == 2'b11) ? 2'b10 : {1'b0, op[0]};
        dec[B_BYTE] = (op == 6'd32) || (op == 6'd36);
        dec[B_SX2]  = (op == 6'd32) || (op == 6'd33);
      end
    end
    dec[3:0] = alu;
    ctrl_n   = legal ? dec : '0;
  end

  assign is_sys = (op == 6'd0) && (func == 6'd12);
  assign wreg_n = ctrl_n[B_JAL] ? 5'd31 : (ctrl_n[B_RDST] ? instr[15:11] : instr[20:16]);

  // ---------------- handshake / hazard ----------------
  state_t         state, state_n;
  logic [DCW-1:0] drain_cnt, drain_cnt_n;
  logic [SCW-1:0] stall_cnt;
  logic           load_en, ld_match, hazard, accept;

  assign load_en  = !out_valid || out_ready;
  // consumer presented while ID/EX holds a load writing one of its sources
  assign ld_match = (LOAD_USE_STALL != 0) && out_valid && ctrl_o[B_MTR] && in_valid &&
                    (instr_o[20:16] != 5'd0) &&
                    ((instr_o[20:16] == instr[25:21]) || (instr_o[20:16] == instr[20:16]));
  assign hazard   = ld_match || (stall_cnt != '0);
  assign in_ready = (state == RUN) && !hazard && load_en && !flush;
  assign accept   = in_valid && in_ready;
  assign halted_o = (state == HALTED);

  // stall counter holds the bubbles still owed after the load leaves ID/EX
  always_ff @(posedge clk) begin
    if (rst || flush)          stall_cnt <= '0;
    else if (ld_match)         stall_cnt <= STALL_RELOAD;
    else if (stall_cnt != '0)  stall_cnt <= stall_cnt - 1'b1;
  end

  // ---------------- ID/EX register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctrl_o    <= '0;
      wreg_o    <= '0;
      instr_o   <= '0;
      illegal_o <= 1'b0;
    end else begin
      illegal_o <= accept && !legal;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (load_en) begin
        out_valid <= accept;
        if (accept) begin
          ctrl_o  <= ctrl_n;
          wreg_o  <= wreg_n;
          instr_o <= instr;
        end
      end
    end
  end

  // ---------------- syscall drain / halt FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    drain_cnt_n = drain_cnt;
    case (state)
      RUN: if (accept && is_sys) begin
        state_n     = DRAIN;
        drain_cnt_n = DRAIN_RELOAD;
      end
      DRAIN: if (drain_cnt == '0) state_n = HALTED;
             else drain_cnt_n = drain_cnt - 1'b1;
      HALTED: if (resume) state_n = RUN;
      default: state_n = RUN;
    endcase
  end
endmodule

// File: tb/tb_pipelined_decode_stage.sv
module tb_pipelined_decode_stage;
  localparam int DRAIN = 3;

  localparam logic [31:0] I_ADD  = 32'h01094820, I_LW  = 32'h8C080000, I_ORI = 32'h350800FF;
  localparam logic [31:0] I_SYS  = 32'h0000000C, I_ILL = 32'hFC000000, I_JAL = 32'h0C000010;
  localparam logic [31:0] I_LB   = 32'h80090004, I_SW  = 32'hAC0A0008, I_SRAV = 32'h00A41807;
  localparam logic [31:0] I_LUI  = 32'h3C011234, I_JR  = 32'h03E00008;

  localparam logic [23:0] C_ADD = 24'h000285, C_LW  = 24'h2001D5, C_ORI  = 24'h0000C8;
  localparam logic [23:0] C_SYS = 24'h00000D, C_JAL = 24'h00608D, C_LB   = 24'hC001D5;
  localparam logic [23:0] C_SW  = 24'h200165, C_SRAV = 24'h008281, C_LUI = 24'h0100C0;
  localparam logic [23:0] C_JR  = 24'h00300D;

  logic        clk = 0, rst, in_valid, in_ready, out_valid, out_ready;
  logic        flush, resume, halted_o, illegal_o;
  logic [31:0] instr, instr_o;
  logic [23:0] ctrl_o;
  logic [4:0]  wreg_o;

  typedef struct {logic [31:0] ins; logic [23:0] ctrl; logic [4:0] wreg;} exp_t;
  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0;

  pipelined_decode_stage #(.LOAD_USE_STALL(1), .DRAIN_CYCLES(DRAIN), .CTRL_W(24)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl_o(ctrl_o), .wreg_o(wreg_o),
    .instr_o(instr_o), .flush(flush), .resume(resume), .halted_o(halted_o),
    .illegal_o(illegal_o));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [23:0] c, input logic [4:0] w);
    exp_t e;
    e.ins = i; e.ctrl = c; e.wreg = w;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // present an instr until accepted, queueing its expected ID/EX contents
  task automatic send(input logic [31:0] i, input logic [23:0] c, input logic [4:0] w);
    bit done = 0;
    in_valid = 1; instr = i;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin push(i, c, w); done = 1; end
      tick();
    end
    in_valid = 0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: instr %h never accepted", i);
    end
  endtask

  // scoreboard monitor: compare whatever EX consumes
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_out: instr_o %h with empty scoreboard", instr_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr", instr_o, e.ins);
        chk("sb_ctrl", {8'd0, ctrl_o}, {8'd0, e.ctrl});
        chk("sb_wreg", {27'd0, wreg_o}, {27'd0, e.wreg});
      end
    end
  end

  initial begin
    rst = 1; in_valid = 0; instr = 0; out_ready = 1; flush = 0; resume = 0;
    tick(); tick(); rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ctrl", {8'd0, ctrl_o}, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_halted", halted_o, 0);
    chk("rst_illegal", illegal_o, 0);
    tick();

    // single add, latency 1
    instr = I_ADD; in_valid = 1;
    @(negedge clk); chk("add_in_ready", in_ready, 1); push(I_ADD, C_ADD, 5'd9);
    tick(); in_valid = 0;
    @(negedge clk); chk("add_out_valid", out_valid, 1); chk("add_illegal", illegal_o, 0);
    tick();

    // load-use: lw $8 then add using $8 -> one bubble
    instr = I_LW; in_valid = 1;
    @(negedge clk); chk("lw_in_ready", in_ready, 1); push(I_LW, C_LW, 5'd8);
    tick(); instr = I_ADD;
    @(negedge clk); chk("lu_stall", in_ready, 0); chk("lw_out_valid", out_valid, 1);
    tick();
    @(negedge clk); chk("lu_bubble", out_valid, 0); chk("lu_ready_again", in_ready, 1);
    push(I_ADD, C_ADD, 5'd9);
    tick(); in_valid = 0;
    @(negedge clk); chk("add_after_lw", out_valid, 1);
    tick();

    // backpressure: hold ID/EX for 3 cycles
    send(I_ADD, C_ADD, 5'd9);
    out_ready = 0; instr = I_ORI; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_ctrl", {8'd0, ctrl_o}, {8'd0, C_ADD});
      chk("hold_instr", instr_o, I_ADD);
      chk("hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1;
    @(negedge clk); chk("hold_release", in_ready, 1); push(I_ORI, C_ORI, 5'd8);
    tick(); in_valid = 0;

    // decode coverage, back to back; lb then add $9 exercises a stall
    send(I_JAL, C_JAL, 5'd31);
    send(I_LB, C_LB, 5'd9);
    send(I_SRAV, C_SRAV, 5'd3);
    send(I_SW, C_SW, 5'd10);
    send(I_LUI, C_LUI, 5'd1);
    send(I_JR, C_JR, 5'd0);
    send(I_LB, C_LB, 5'd9);
    send(I_ADD, C_ADD, 5'd9);
    tick();

    // flush kills held ID/EX and refuses the presented lw
    send(I_ORI, C_ORI, 5'd8);
    out_ready = 0; flush = 1; in_valid = 1; instr = I_LW;
    @(negedge clk); chk("flush_in_ready", in_ready, 0);
    void'(exp_q.pop_back());
    tick(); flush = 0; in_valid = 0; out_ready = 1;
    @(negedge clk); chk("flush_out_valid", out_valid, 0);
    tick();

    // illegal opcode issues with zero ctrl and pulses illegal_o
    instr = I_ILL; in_valid = 1;
    @(negedge clk); chk("ill_in_ready", in_ready, 1); push(I_ILL, 24'h0, 5'd0);
    tick(); in_valid = 0;
    @(negedge clk); chk("ill_pulse", illegal_o, 1); chk("ill_valid", out_valid, 1);
    tick();
    @(negedge clk); chk("ill_pulse_end", illegal_o, 0);
    tick();

    // syscall drain -> halt -> resume
    instr = I_SYS; in_valid = 1;
    @(negedge clk); chk("sys_in_ready", in_ready, 1); push(I_SYS, C_SYS, 5'd0);
    tick(); instr = I_ADD;
    for (int i = 0; i <= DRAIN; i++) begin
      @(negedge clk);
      chk("drain_in_ready", in_ready, 0);
      chk("halt_timing", halted_o, (i >= DRAIN) ? 1 : 0);
      tick();
    end
    in_valid = 0; resume = 1;
    @(negedge clk); chk("halted_hold", halted_o, 1);
    tick(); resume = 0;
    @(negedge clk); chk("resume_in_ready", in_ready, 1); chk("resume_halted", halted_o, 0);
    tick();

    // reset while ID/EX holds a stalled instr
    instr = I_ADD; in_valid = 1;
    @(negedge clk); chk("pre_rst_ready", in_ready, 1); push(I_ADD, C_ADD, 5'd9);
    tick(); in_valid = 0; out_ready = 0; rst = 1;
    tick(); rst = 0; out_ready = 1;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ctrl", {8'd0, ctrl_o}, 0);
    tick();

    repeat (4) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
